// File: rtl/audio_pkg.sv
// audio_pkg: constants shared by the I2S transmit and receive paths,
// plus the receiver frame-tracking state encoding.
package audio_pkg;
    localparam int DefaultDataWidth = 16;
    localparam int SysClkHz = 100_000_000;
    localparam int I2sBitClkDiv = 76;
    localparam int FrameWords = 2;
    typedef enum logic [1:0] {RxSync, RxLeft, RxRight} rxState_t;
endpackage

// File: rtl/i2s_pin_sync.sv
// i2s_pin_sync: flop chain for an asynchronous I2S pin with registered rising-edge detect.
module i2s_pin_sync #(
    parameter int Stages = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic pin,
    output logic level,
    output logic rise
);
    logic [Stages-1:0] chain;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            chain <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= (chain << 1) | Stages'(pin);
            level <= chain[Stages-1];
            rise  <= chain[Stages-1] & ~level;
        end
    end
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: synchronizes an external I2S stream and delivers {left, right} frames
// through a single-entry valid/ready holding register.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int DataWidth  = DefaultDataWidth,
    parameter int SyncStages = 2
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   I2S_CLK,
    input  logic                   I2S_WS,
    input  logic                   I2S_DATA,
    output logic [2*DataWidth-1:0] OutputData,
    output logic                   DataValid,
    input  logic                   DataReady,
    output logic                   Overrun,
    output logic                   FrameError,
    input  logic                   ClearStatus
);
    localparam int CntW = $clog2(DataWidth + 1);

    logic                   clkRise;
    logic [SyncStages:0]    wsChain;
    logic [SyncStages:0]    dataChain;
    logic                   ws;
    logic                   bitIn;
    rxState_t               state;
    logic                   lastWs;
    logic [CntW-1:0]        bitCnt;
    logic [CntW-1:0]        cntNext;
    logic [DataWidth-1:0]   shiftReg;
    logic [DataWidth-1:0]   wordNext;
    logic [DataWidth-1:0]   leftWord;
    logic [2*DataWidth-1:0] frameData;
    logic                   frameDone;
    logic                   boundary;
    logic                   shortWord;

    i2s_pin_sync #(.Stages(SyncStages)) clkSync (
        .CLK  (CLK),
        .Reset(Reset),
        .pin  (I2S_CLK),
        .level(),
        .rise (clkRise)
    );

    // One flop longer than the clock chain so WS/DATA line up with the registered edge pulse
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wsChain   <= '0;
            dataChain <= '0;
        end else begin
            wsChain   <= {wsChain[SyncStages-1:0], I2S_WS};
            dataChain <= {dataChain[SyncStages-1:0], I2S_DATA};
        end
    end

    assign ws    = wsChain[SyncStages];
    assign bitIn = dataChain[SyncStages];

    always_comb begin
        wordNext  = bitCnt < CntW'(DataWidth) ? {shiftReg[DataWidth-2:0], bitIn} : shiftReg;
        cntNext   = bitCnt < CntW'(DataWidth) ? bitCnt + CntW'(1) : bitCnt;
        boundary  = clkRise && (ws != lastWs);
        shortWord = cntNext < CntW'(DataWidth);
    end

    // The boundary bit is the LSB slot of the word that is ending
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state      <= RxSync;
            lastWs     <= 1'b0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            leftWord   <= '0;
            frameData  <= '0;
            frameDone  <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            frameDone  <= 1'b0;
            FrameError <= 1'b0;
            if (clkRise)
                lastWs <= ws;
            if (!Enable) begin
                state    <= RxSync;
                bitCnt   <= '0;
                shiftReg <= '0;
            end else if (clkRise) begin
                bitCnt   <= boundary ? '0 : cntNext;
                shiftReg <= boundary ? '0 : wordNext;
                if (boundary) begin
                    case (state)
                        RxSync: if (!ws) state <= RxLeft;
                        RxLeft: begin
                            if (shortWord) begin
                                FrameError <= 1'b1;
                                state      <= RxSync;
                            end else begin
                                leftWord <= wordNext;
                                state    <= RxRight;
                            end
                        end
                        RxRight: begin
                            if (shortWord) begin
                                FrameError <= 1'b1;
                                state      <= RxSync;
                            end else begin
                                frameData <= {leftWord, wordNext};
                                frameDone <= 1'b1;
                                state     <= RxLeft;
                            end
                        end
                        default: state <= RxSync;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            OutputData <= '0;
            DataValid  <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            if (frameDone && (!DataValid || DataReady)) begin
                OutputData <= frameData;
                DataValid  <= 1'b1;
            end else if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end
            if (frameDone && DataValid && !DataReady)
                Overrun <= 1'b1;
            else if (ClearStatus)
                Overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives I2S word streams and checks accepted frames against
// a word-level model (MSB-aligned truncation, sync loss on short words).
module tb_i2s_receiver;
    localparam int DW = 16;
    localparam int H  = 4;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    logic Enable = 1'b1;
    logic I2S_CLK = 1'b0;
    logic I2S_WS = 1'b0;
    logic I2S_DATA = 1'b0;
    logic DataReady = 1'b1;
    logic ClearStatus = 1'b0;
    logic [2*DW-1:0] OutputData;
    logic DataValid;
    logic Overrun;
    logic FrameError;

    int tests = 0;
    int fails = 0;
    int errHigh = 0;
    logic [31:0] gotQ[$];
    logic [31:0] expQ[$];

    always #5 CLK = ~CLK;

    i2s_receiver #(.DataWidth(DW), .SyncStages(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Enable     (Enable),
        .I2S_CLK    (I2S_CLK),
        .I2S_WS     (I2S_WS),
        .I2S_DATA   (I2S_DATA),
        .OutputData (OutputData),
        .DataValid  (DataValid),
        .DataReady  (DataReady),
        .Overrun    (Overrun),
        .FrameError (FrameError),
        .ClearStatus(ClearStatus)
    );

    always @(negedge CLK) begin
        if (DataValid && DataReady) gotQ.push_back(OutputData);
        if (FrameError) errHigh++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic sendBit(input logic wsBit, input logic d);
        @(negedge CLK);
        I2S_WS = wsBit;
        I2S_DATA = d;
        repeat (H) @(negedge CLK);
        I2S_CLK = 1'b1;
        repeat (H) @(negedge CLK);
        I2S_CLK = 1'b0;
    endtask

    // I2S one-bit delay: a word's LSB travels with the other channel's WS
    task automatic sendWord(input logic ch, input logic [31:0] val, input int w);
        for (int i = w - 1; i >= 0; i--) sendBit(i == 0 ? ~ch : ch, val[i]);
    endtask

    task automatic sendFrame(input logic [31:0] l, input logic [31:0] r, input int wl, input int wr);
        sendWord(1'b0, l, wl);
        sendWord(1'b1, r, wr);
    endtask

    function automatic logic [15:0] modelWord(input logic [31:0] v, input int w);
        return 16'(v >> (w - DW));
    endfunction

    function automatic logic [31:0] randWord(input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        return $urandom & mask;
    endfunction

    task automatic test_reset;
        Reset = 1'b0;
        repeat (4) @(negedge CLK);
        tests++; if (OutputData !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected %h", OutputData, 32'h0); end
        tests++; if (DataValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", DataValid); end
        tests++; if (Overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", Overrun); end
        tests++; if (FrameError !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", FrameError); end
        Reset = 1'b1;
        sendWord(1'b1, 32'h5, 3);
    endtask

    task automatic test_basic;
        logic [31:0] got;
        gotQ.delete();
        sendFrame(32'h1234, 32'hABCD, 16, 16);
        repeat (20) @(negedge CLK);
        got = gotQ.size() > 0 ? gotQ[0] : 32'hx;
        tests++; if (gotQ.size() !== 1) begin fails++; $display("FAIL basic_count: got %0d frames expected 1", gotQ.size()); end
        tests++; if (got !== 32'h1234ABCD) begin fails++; $display("FAIL basic_data: got %h expected %h", got, 32'h1234ABCD); end
        tests++; if (DataValid !== 1'b0) begin fails++; $display("FAIL basic_valid_clear: got %b expected 0", DataValid); end
    endtask

    task automatic test_latency;
        logic [31:0] l;
        logic [31:0] r;
        l = randWord(16);
        r = randWord(16);
        sendWord(1'b0, l, 16);
        for (int i = 15; i >= 1; i--) sendBit(1'b1, r[i]);
        @(negedge CLK);
        I2S_WS = 1'b0;
        I2S_DATA = r[0];
        repeat (H) @(negedge CLK);
        I2S_CLK = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        tests++; if (DataValid !== 1'b0) begin fails++; $display("FAIL latency_early: got %b at edge N+3 expected 0", DataValid); end
        @(posedge CLK);
        #1;
        tests++; if (DataValid !== 1'b1) begin fails++; $display("FAIL latency_edge: got %b at edge N+4 expected 1", DataValid); end
        tests++; if (OutputData !== {l[15:0], r[15:0]}) begin fails++; $display("FAIL latency_data: got %h expected %h", OutputData, {l[15:0], r[15:0]}); end
        repeat (H) @(negedge CLK);
        I2S_CLK = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] got;
        int wl;
        int wr;
        gotQ.delete();
        expQ.delete();
        for (int f = 0; f < 6; f++) begin
            wl = $urandom_range(20, 16);
            wr = $urandom_range(20, 16);
            l = randWord(wl);
            r = randWord(wr);
            expQ.push_back({modelWord(l, wl), modelWord(r, wr)});
            sendFrame(l, r, wl, wr);
        end
        repeat (20) @(negedge CLK);
        tests++; if (gotQ.size() !== expQ.size()) begin fails++; $display("FAIL random_count: got %0d frames expected %0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = i < gotQ.size() ? gotQ[i] : 32'hx;
            tests++; if (got !== expQ[i]) begin fails++; $display("FAIL random_frame%0d: got %h expected %h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_overrun;
        logic [31:0] got;
        gotQ.delete();
        DataReady = 1'b0;
        sendFrame(32'h8001, 32'h7FFE, 16, 16);
        sendFrame(32'h0F0F, 32'hF0F0, 16, 16);
        repeat (20) @(negedge CLK);
        tests++; if (DataValid !== 1'b1) begin fails++; $display("FAIL overrun_valid: got %b expected 1", DataValid); end
        tests++; if (OutputData !== 32'h80017FFE) begin fails++; $display("FAIL overrun_hold: got %h expected %h", OutputData, 32'h80017FFE); end
        tests++; if (Overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", Overrun); end
        repeat (5) @(negedge CLK);
        tests++; if (Overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", Overrun); end
        ClearStatus = 1'b1;
        @(negedge CLK);
        ClearStatus = 1'b0;
        tests++; if (Overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b expected 0", Overrun); end
        tests++; if (DataValid !== 1'b1) begin fails++; $display("FAIL overrun_valid_kept: got %b expected 1", DataValid); end
        DataReady = 1'b1;
        repeat (3) @(negedge CLK);
        got = gotQ.size() > 0 ? gotQ[0] : 32'hx;
        tests++; if (gotQ.size() !== 1) begin fails++; $display("FAIL overrun_drain_count: got %0d frames expected 1", gotQ.size()); end
        tests++; if (got !== 32'h80017FFE) begin fails++; $display("FAIL overrun_drain_data: got %h expected %h", got, 32'h80017FFE); end
        tests++; if (DataValid !== 1'b0) begin fails++; $display("FAIL overrun_drained: got %b expected 0", DataValid); end
    endtask

    task automatic test_frame_error;
        logic [31:0] got;
        gotQ.delete();
        errHigh = 0;
        sendWord(1'b0, randWord(12), 12);
        sendWord(1'b1, randWord(16), 16);
        sendFrame(32'h5555, 32'hAAAA, 16, 16);
        repeat (20) @(negedge CLK);
        got = gotQ.size() > 0 ? gotQ[0] : 32'hx;
        tests++; if (errHigh !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d high cycles expected 1", errHigh); end
        tests++; if (gotQ.size() !== 1) begin fails++; $display("FAIL ferr_count: got %0d frames expected 1", gotQ.size()); end
        tests++; if (got !== 32'h5555AAAA) begin fails++; $display("FAIL ferr_next: got %h expected %h", got, 32'h5555AAAA); end
    endtask

    task automatic test_truncate;
        logic [31:0] got;
        gotQ.delete();
        sendFrame(32'hFFFF0, 32'h00001, 20, 20);
        repeat (20) @(negedge CLK);
        got = gotQ.size() > 0 ? gotQ[0] : 32'hx;
        tests++; if (gotQ.size() !== 1) begin fails++; $display("FAIL trunc_count: got %0d frames expected 1", gotQ.size()); end
        tests++; if (got !== 32'hFFFF0000) begin fails++; $display("FAIL trunc_data: got %h expected %h", got, 32'hFFFF0000); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] got;
        r = randWord(16);
        sendWord(1'b0, randWord(16), 16);
        for (int i = 15; i >= 8; i--) sendBit(1'b1, r[i]);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (3) @(negedge CLK);
        tests++; if (OutputData !== 32'h0) begin fails++; $display("FAIL midreset_data: got %h expected %h", OutputData, 32'h0); end
        tests++; if (DataValid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", DataValid); end
        tests++; if (Overrun !== 1'b0) begin fails++; $display("FAIL midreset_overrun: got %b expected 0", Overrun); end
        tests++; if (FrameError !== 1'b0) begin fails++; $display("FAIL midreset_ferr: got %b expected 0", FrameError); end
        Reset = 1'b1;
        gotQ.delete();
        sendWord(1'b1, r, 8);
        l = randWord(16);
        r = randWord(16);
        sendFrame(l, r, 16, 16);
        repeat (20) @(negedge CLK);
        got = gotQ.size() > 0 ? gotQ[0] : 32'hx;
        tests++; if (gotQ.size() !== 1) begin fails++; $display("FAIL midreset_count: got %0d frames expected 1", gotQ.size()); end
        tests++; if (got !== {l[15:0], r[15:0]}) begin fails++; $display("FAIL midreset_frame: got %h expected %h", got, {l[15:0], r[15:0]}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_random();
        test_overrun();
        test_frame_error();
        test_truncate();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter DataWidth, default 16, bits per channel word.
REQ-002 Parameter SyncStages, default 2, synchronizer depth for the I2S pins.
REQ-003 CLK  input  1  system clock, 100 MHz (MasterCLK domain); all logic on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset (0 = reset) sampled on CLK rising edge.
REQ-005 Enable  input  1  1 = receive frames; 0 = abort current frame and hold FSM in SYNC.
REQ-006 I2S_CLK  input  1  external serial bit clock from the ADC (~1.312 MHz), asynchronous to CLK.
REQ-007 I2S_WS  input  1  external word select; 0 = left channel, 1 = right channel.
REQ-008 I2S_DATA  input  1  external serial data, MSB first.
REQ-009 OutputData  output  2*DataWidth  {left, right} stereo sample, same packing as DAC path input.
REQ-010 DataValid  output  1  OutputData holds an unconsumed frame.
REQ-011 DataReady  input  1  consumer accepts OutputData when DataValid && DataReady on a CLK edge.
REQ-012 Overrun  output  1  sticky: a completed frame was dropped because the holding register was full.
REQ-013 FrameError  output  1  one-cycle pulse: a channel word ended with fewer than DataWidth bits.
REQ-014 ClearStatus  input  1  1 for one cycle clears Overrun.

Function
REQ-015 I2S_CLK, I2S_WS, I2S_DATA SHALL each pass through SyncStages flops; a rising edge is detected when sync output is 1 and the previous sync value was 0.
REQ-016 On each detected I2S_CLK rising edge, synchronized WS and DATA SHALL be sampled together (one "bit event").
REQ-017 A bit event whose WS differs from the WS of the previous bit event SHALL be a "boundary"; its DATA bit is the LSB slot of the ending word (I2S one-bit delay).
REQ-018 Bit count per word SHALL include the boundary bit; bits beyond DataWidth SHALL be discarded (word is MSB-aligned, truncated).
REQ-019 Word shorter than DataWidth at a boundary SHALL pulse FrameError and discard the whole current frame; FSM SHALL go to SYNC.
REQ-020 FSM states: SYNC (wait for boundary with WS 1->0), LEFT (accumulate left word), RIGHT (accumulate right word).
REQ-021 SYNC->LEFT on boundary WS 1->0; LEFT->RIGHT on boundary WS 0->1 (left word latched); RIGHT->LEFT on boundary WS 1->0 (frame complete).
REQ-022 Word count of the first partial word after SYNC SHALL NOT raise FrameError.
REQ-023 Frame complete with DataValid=0 or (DataValid && DataReady) in the same cycle: OutputData loads {left,right}, DataValid=1 next cycle.
REQ-024 Frame complete with DataValid=1 and DataReady=0: new frame dropped, OutputData unchanged, Overrun set.
REQ-025 DataValid SHALL clear on the cycle after DataValid && DataReady unless REQ-023 reloads it.
REQ-026 Latency: DataValid SHALL be 1 at CLK edge N+SyncStages+2, N = first edge sampling the frame-ending I2S_CLK high.
REQ-027 ClearStatus concurrent with a new overrun: set wins.
REQ-028 Enable=0: FSM to SYNC, bit counter and shift register cleared; DataValid/OutputData/Overrun retained.

Reset
REQ-029 Reset=0: FSM=SYNC, OutputData=0, DataValid=0, Overrun=0, FrameError=0, counters, shift register and sync flops cleared.
REQ-030 Reset mid-frame SHALL discard the partial frame; first output after release is the first complete frame following a WS 1->0 boundary.

Structure
REQ-031 FSM state encoding and DataWidth default SHALL live in shared package audio_pkg with the I2S transmitter constants.
REQ-032 One sub-module i2s_pin_sync (SyncStages flop chain plus rising-edge detect) SHALL be instantiated for I2S_CLK; WS and DATA use matching delay chains.

Verification
REQ-033 Frames 0x1234/0xABCD, DataReady=1 -> OutputData=0x1234ABCD, DataValid one cycle per frame.
REQ-034 Frame 0x8001/0x7FFE, DataReady held 0, second frame 0x0F0F/0xF0F0 -> OutputData stays 0x80017FFE, Overrun=1; ClearStatus -> Overrun=0.
REQ-035 Left word of 12 bits -> FrameError one-cycle pulse, no DataValid; next good frame 0x5555/0xAAAA output.
REQ-036 20-bit slots carrying 0xFFFF0/0x00001 -> OutputData=0xFFFF0000.
REQ-037 Reset=0 asserted mid-right-word -> all outputs 0; after release, first output equals next full frame.
REQ-038 Measure latency: DataValid at edge N+4 with SyncStages=2.
